// File: rtl/tick_sched_pkg.sv
// Shared types and constants for the two-channel tick scheduler.
package tick_sched_pkg;

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_RUN      = 2'd1,
    ST_PEND_UPD = 2'd2,
    ST_PEND_OFF = 2'd3
  } chan_state_t;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  localparam int DIV_A_DEFAULT = 4;
  localparam int DIV_B_DEFAULT = 49;

endpackage

// File: rtl/tick_sched_channel.sv
// One divider channel: half-period counter, shadow divisor and update/stop FSM.
module tick_channel
  import tick_sched_pkg::*;
#(
  parameter int CW      = 8,
  parameter int DIV_RST = 4
) (
  input  logic          clock1M,
  input  logic          reset,
  input  logic          wr_accept,
  input  logic [CW-1:0] wr_div,
  input  logic          wr_en,
  output logic          ready,
  output logic          sq_clk,
  output logic          tick,
  output logic          busy
);

  localparam logic [CW-1:0] DIV_RST_V = CW'(DIV_RST);
  localparam logic [CW-1:0] ZERO      = {CW{1'b0}};
  localparam logic [CW-1:0] ONE       = {{(CW-1){1'b0}}, 1'b1};

  chan_state_t   state_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] div_r;
  logic [CW-1:0] shadow_r;
  logic [CW-1:0] count_nxt_s;
  logic          clk_r;
  logic          tick_r;
  logic          busy_r;
  logic          terminal_s;

  // Terminal-count detect and next counter value
  always_comb begin
    terminal_s = (count_r == div_r);
    if (terminal_s) begin
      count_nxt_s = ZERO;
    end else begin
      count_nxt_s = count_r + ONE;
    end
  end

  assign ready  = (state_r == ST_OFF) || (state_r == ST_RUN);
  assign sq_clk = clk_r;
  assign tick   = tick_r;
  assign busy   = busy_r;

  // Channel FSM; writes take effect only at a terminal count, never mid half-period
  always_ff @(posedge clock1M or posedge reset) begin
    if (reset) begin
      state_r  <= ST_RUN;
      count_r  <= ZERO;
      div_r    <= DIV_RST_V;
      shadow_r <= ZERO;
      clk_r    <= 1'b0;
      tick_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_OFF: begin
          count_r <= ZERO;
          clk_r   <= 1'b0;
          tick_r  <= 1'b0;
          busy_r  <= 1'b0;
          if (wr_accept) begin
            div_r <= wr_div;
            if (wr_en) begin
              state_r <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          count_r <= count_nxt_s;
          clk_r   <= clk_r ^ terminal_s;
          tick_r  <= terminal_s;
          if (wr_accept) begin
            shadow_r <= wr_div;
            busy_r   <= 1'b1;
            state_r  <= wr_en ? ST_PEND_UPD : ST_PEND_OFF;
          end
        end
        ST_PEND_UPD: begin
          count_r <= count_nxt_s;
          clk_r   <= clk_r ^ terminal_s;
          tick_r  <= terminal_s;
          if (terminal_s) begin
            div_r   <= shadow_r;
            busy_r  <= 1'b0;
            state_r <= ST_RUN;
          end
        end
        ST_PEND_OFF: begin
          count_r <= count_nxt_s;
          clk_r   <= clk_r ^ terminal_s;
          tick_r  <= terminal_s;
          // Stop only on the falling toggle so the output never parks high
          if (terminal_s && clk_r) begin
            div_r   <= shadow_r;
            busy_r  <= 1'b0;
            state_r <= ST_OFF;
          end
        end
        default: begin
          state_r <= ST_OFF;
          count_r <= ZERO;
          clk_r   <= 1'b0;
          tick_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/tick_sched.sv
// Two independent square-wave/tick generators sharing one configuration port.
module tick_sched
  import tick_sched_pkg::*;
#(
  parameter int CW        = 8,
  parameter int DIV_A_RST = DIV_A_DEFAULT,
  parameter int DIV_B_RST = DIV_B_DEFAULT
) (
  input  logic          clock1M,
  input  logic          reset,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic          cfg_chan,
  input  logic [CW-1:0] cfg_div,
  input  logic          cfg_en,
  output logic          clk_a,
  output logic          clk_b,
  output logic          tick_a,
  output logic          tick_b,
  output logic [1:0]    busy
);

  logic ready_a_s;
  logic ready_b_s;
  logic ready_s;
  logic acc_a_s;
  logic acc_b_s;
  logic busy_a_s;
  logic busy_b_s;

  // Route the request to the addressed channel and qualify it with that channel's ready
  always_comb begin
    if (cfg_chan == CH_B) begin
      ready_s = ready_b_s;
    end else begin
      ready_s = ready_a_s;
    end
    acc_a_s = cfg_valid && ready_s && (cfg_chan == CH_A);
    acc_b_s = cfg_valid && ready_s && (cfg_chan == CH_B);
  end

  assign cfg_ready = ready_s;
  assign busy      = {busy_b_s, busy_a_s};

  tick_channel #(
    .CW      (CW),
    .DIV_RST (DIV_A_RST)
  ) u_chan_a (
    .clock1M   (clock1M),
    .reset     (reset),
    .wr_accept (acc_a_s),
    .wr_div    (cfg_div),
    .wr_en     (cfg_en),
    .ready     (ready_a_s),
    .sq_clk    (clk_a),
    .tick      (tick_a),
    .busy      (busy_a_s)
  );

  tick_channel #(
    .CW      (CW),
    .DIV_RST (DIV_B_RST)
  ) u_chan_b (
    .clock1M   (clock1M),
    .reset     (reset),
    .wr_accept (acc_b_s),
    .wr_div    (cfg_div),
    .wr_en     (cfg_en),
    .ready     (ready_b_s),
    .sq_clk    (clk_b),
    .tick      (tick_b),
    .busy      (busy_b_s)
  );

endmodule

// File: tb/tb_tick_sched.sv
// Bench for tick_sched: event-schedule model compared every cycle, plus directed literal checks.
module tb_tick_sched;

  logic       clock1M   = 1'b0;
  logic       reset     = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_chan  = 1'b0;
  logic       cfg_en    = 1'b0;
  logic [7:0] cfg_div   = 8'd0;
  logic       cfg_ready;
  logic       clk_a, clk_b, tick_a, tick_b;
  logic [1:0] busy;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;
  int acc_e    = 0;

  // Model: per channel, the absolute edge of the next toggle and any queued request
  bit m_on   [2];
  bit m_lvl  [2];
  bit m_tick [2];
  int m_n    [2];
  int m_next [2];
  int m_pend [2];   // 0 none, 1 new divisor, 2 stop
  int m_pn   [2];
  bit wr_s   [2];

  tick_sched u_dut (
    .clock1M   (clock1M),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_div   (cfg_div),
    .cfg_en    (cfg_en),
    .clk_a     (clk_a),
    .clk_b     (clk_b),
    .tick_a    (tick_a),
    .tick_b    (tick_b),
    .busy      (busy)
  );

  always #5 clock1M = ~clock1M;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    edge_n = 0;
    for (int c = 0; c < 2; c++) begin
      m_on[c]   = 1'b1;
      m_lvl[c]  = 1'b0;
      m_tick[c] = 1'b0;
      m_n[c]    = (c == 0) ? 4 : 49;
      m_next[c] = m_n[c] + 1;
      m_pend[c] = 0;
      m_pn[c]   = 0;
    end
  endtask

  task automatic step_ch(input int c, input int e, input bit wr, input int div, input bit en);
    bit was_on;
    int was_pend;
    was_on   = m_on[c];
    was_pend = m_pend[c];
    m_tick[c] = 1'b0;
    if (was_on && e == m_next[c]) begin
      m_lvl[c]  = ~m_lvl[c];
      m_tick[c] = 1'b1;
      if (was_pend == 1) begin
        m_n[c]    = m_pn[c];
        m_pend[c] = 0;
      end else if (was_pend == 2 && m_lvl[c] == 1'b0) begin
        m_on[c]   = 1'b0;
        m_n[c]    = m_pn[c];
        m_pend[c] = 0;
      end
      m_next[c] = e + m_n[c] + 1;
    end
    if (wr) begin
      if (!was_on) begin
        m_n[c] = div;
        if (en) begin
          m_on[c]   = 1'b1;
          m_lvl[c]  = 1'b0;
          m_next[c] = e + div + 1;
        end
      end else if (was_pend == 0) begin
        m_pend[c] = en ? 1 : 2;
        m_pn[c]   = div;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock1M or posedge reset);
      if (reset) begin
        model_reset();
      end else begin
        edge_n++;
        wr_s[0] = cfg_valid && (cfg_chan == 1'b0) && (m_pend[0] == 0);
        wr_s[1] = cfg_valid && (cfg_chan == 1'b1) && (m_pend[1] == 0);
        step_ch(0, edge_n, wr_s[0], int'(cfg_div), cfg_en);
        step_ch(1, edge_n, wr_s[1], int'(cfg_div), cfg_en);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock1M);
      chk("clk_a",  16'(clk_a),  16'(m_lvl[0]));
      chk("tick_a", 16'(tick_a), 16'(m_tick[0]));
      chk("clk_b",  16'(clk_b),  16'(m_lvl[1]));
      chk("tick_b", 16'(tick_b), 16'(m_tick[1]));
      chk("busy",   16'(busy),   16'({m_pend[1] != 0, m_pend[0] != 0}));
      chk("cfg_ready", 16'(cfg_ready), 16'(m_pend[cfg_chan] == 0));
    end
  end

  task automatic at_edge(input int k);
    int guard;
    guard = 0;
    while (edge_n < k && guard < 2000) begin
      @(posedge clock1M);
      #1;
      guard++;
    end
    chk("edge_sync", 16'(edge_n), 16'(k));
  endtask

  task automatic cfg_write(input bit chan, input int div, input bit en, output int e);
    bit acc;
    acc       = 1'b0;
    cfg_valid = 1'b1;
    cfg_chan  = chan;
    cfg_div   = 8'(div);
    cfg_en    = en;
    for (int i = 0; i < 400 && !acc; i++) begin
      @(negedge clock1M);
      acc = cfg_ready;
      @(posedge clock1M);
      #1;
    end
    cfg_valid = 1'b0;
    if (!acc) begin
      chk("cfg_write_timeout", 16'h0, 16'h1);
    end
    e = edge_n;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clock1M);
    #1;
    reset = 1'b0;

    // Free-running defaults out of reset
    at_edge(5);  chk("a_first_tick",  16'({clk_a, tick_a}), 16'h3);
    at_edge(6);  chk("a_tick_single", 16'(tick_a), 16'h0);
    at_edge(10); chk("a_fall",        16'({clk_a, tick_a}), 16'h1);
    at_edge(49); chk("b_before",      16'({clk_b, tick_b}), 16'h0);
    at_edge(50); chk("b_first_tick",  16'({clk_b, tick_b}), 16'h3);

    // Divisor change mid half-period waits for the old terminal count
    at_edge(52);
    cfg_write(1'b0, 9, 1'b1, acc_e);
    chk("a_upd_acc_edge", 16'(acc_e), 16'd53);
    chk("a_upd_busy", 16'(busy), 16'h1);
    at_edge(55); chk("a_upd_apply", 16'({clk_a, tick_a, busy}), 16'hC);
    at_edge(64); chk("a_new_half_0", 16'(tick_a), 16'h0);
    at_edge(65); chk("a_new_half_1", 16'({clk_a, tick_a}), 16'h1);

    // Second write is held off while the first is pending
    at_edge(67);
    cfg_write(1'b0, 2, 1'b1, acc_e);
    chk("a_w1_acc_edge", 16'(acc_e), 16'd68);
    cfg_valid = 1'b1;
    cfg_chan  = 1'b0;
    cfg_div   = 8'd4;
    cfg_en    = 1'b1;
    #1;
    chk("a_held_ready", 16'(cfg_ready), 16'h0);
    cfg_write(1'b0, 4, 1'b1, acc_e);
    chk("a_w2_acc_edge", 16'(acc_e), 16'd76);
    at_edge(78); chk("a_w2_apply", 16'({tick_a, busy}), 16'h4);
    at_edge(82); chk("a_n4_gap",   16'(tick_a), 16'h0);
    at_edge(83); chk("a_n4_tick",  16'({clk_a, tick_a}), 16'h3);
    at_edge(100); chk("b_undisturbed", 16'({clk_b, tick_b}), 16'h1);

    // Stop B while low: one more rise and fall, then parked low
    at_edge(110);
    cfg_write(1'b1, 49, 1'b0, acc_e);
    chk("b_off_busy", 16'(busy), 16'h2);
    at_edge(150); chk("b_off_rise", 16'({clk_b, tick_b, busy[1]}), 16'h7);
    at_edge(200); chk("b_off_fall", 16'({clk_b, tick_b, busy[1]}), 16'h2);
    at_edge(201); chk("b_parked",   16'({clk_b, tick_b}), 16'h0);

    // Stop A, then restart it with N=0
    cfg_write(1'b0, 4, 1'b0, acc_e);
    at_edge(230); chk("all_off", 16'({clk_a, tick_a, clk_b, tick_b, busy}), 16'h0);
    cfg_write(1'b0, 0, 1'b1, acc_e);
    chk("a_n0_acc",  16'({clk_a, tick_a}), 16'h0);
    at_edge(232); chk("a_n0_e1", 16'({clk_a, tick_a}), 16'h3);
    at_edge(233); chk("a_n0_e2", 16'({clk_a, tick_a}), 16'h1);
    at_edge(234); chk("a_n0_e3", 16'({clk_a, tick_a}), 16'h3);

    // Reset while A has a pending update
    at_edge(240);
    cfg_write(1'b0, 7, 1'b1, acc_e);
    chk("a_pend_before_rst", 16'(busy), 16'h1);
    reset = 1'b1;
    #1;
    chk("rst_immediate", 16'({clk_a, tick_a, clk_b, tick_b, busy}), 16'h0);
    repeat (2) @(posedge clock1M);
    #1;
    reset = 1'b0;
    at_edge(5);  chk("rst_a_tick5",  16'({clk_a, tick_a}), 16'h3);
    at_edge(10); chk("rst_a_tick10", 16'({clk_a, tick_a}), 16'h1);
    at_edge(15); chk("rst_a_tick15", 16'({clk_a, tick_a}), 16'h3);
    at_edge(20); chk("rst_a_tick20", 16'({clk_a, tick_a, busy}), 16'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tick_sched.md
TICK_SCHED -- requirements
Module: tick_sched

Interface
REQ-001 Parameter CW, default 8: width of divisor and counter fields.
REQ-002 Parameter DIV_A_RST, default 4: channel A reset divisor (100 kHz from 1 MHz).
REQ-003 Parameter DIV_B_RST, default 49: channel B reset divisor (10 kHz from 1 MHz).
REQ-004 clock1M  input  1  system clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state.
REQ-006 cfg_valid  input  1  configuration write request.
REQ-007 cfg_ready  output  1  write accepted this cycle when high together with cfg_valid.
REQ-008 cfg_chan  input  1  target channel: 0 = A, 1 = B.
REQ-009 cfg_div  input  CW  new half-period divisor N.
REQ-010 cfg_en  input  1  1 = channel runs, 0 = channel stops.
REQ-011 clk_a, clk_b  output  1 each  registered square waves.
REQ-012 tick_a, tick_b  output  1 each  registered one-cycle pulse on every clk_x toggle.
REQ-013 busy  output  2  bit i high while channel i has a pending update.

Function
REQ-014 Each channel SHALL run a counter 0..N; on the cycle count==N it SHALL reset count to 0, toggle clk_x and pulse tick_x; the half-period is N+1 cycles and the full period 2(N+1).
REQ-015 tick_x SHALL be high in exactly the cycle in which clk_x shows its new value; it is otherwise 0.
REQ-016 N=0 SHALL be legal: clk_x toggles every cycle and tick_x stays high continuously.
REQ-017 Per-channel FSM states: OFF, RUN, PEND_UPD, PEND_OFF.
REQ-018 cfg_ready SHALL be combinational: high iff the addressed channel is in OFF or RUN.
REQ-019 Accepted write in OFF, cfg_en=1: load N, clear count, clk_x=0, go RUN next cycle.
REQ-020 Accepted write in OFF, cfg_en=0: store N only, stay OFF.
REQ-021 Accepted write in RUN, cfg_en=1: store N in shadow, go PEND_UPD; the active N is unchanged.
REQ-022 PEND_UPD: at the next count==N (old N), toggle as normal, load shadow N, clear count, go RUN.
REQ-023 Accepted write in RUN, cfg_en=0: store N in shadow, go PEND_OFF.
REQ-024 PEND_OFF: at a terminal count with clk_x=1, toggle clk_x to 0, pulse tick_x, load shadow N, go OFF; at a terminal count with clk_x=0, toggle normally and stay in PEND_OFF; clk_x never stops high.
REQ-025 In OFF, clk_x=0, tick_x=0, and count holds 0.
REQ-026 A write accepted in the same cycle as a terminal count SHALL NOT apply at that terminal count; it applies at the following one.
REQ-027 Channels SHALL be fully independent; writes to one SHALL never perturb the other's phase.
REQ-028 cfg_valid with cfg_ready low SHALL have no effect; the requester holds the request.
REQ-029 busy[i] SHALL be high exactly in PEND_UPD or PEND_OFF.

Reset
REQ-030 On reset assertion, all outputs SHALL clear immediately: clk_x=0, tick_x=0, busy=0.
REQ-031 During and after reset, both channels SHALL be in RUN with count=0, active N = DIV_x_RST, and shadows discarded.
REQ-032 After reset release, the first tick_a SHALL occur on the (DIV_A_RST+1)th rising edge.
REQ-033 A reset during PEND_x SHALL discard the pending write.

Structure
REQ-034 Package tick_sched_pkg SHALL hold the channel-state enum, the channel index constants CH_A=0 and CH_B=1, and the default divisor constants.
REQ-035 One sub-module tick_channel (counter, shadow, and FSM) SHALL be instantiated twice; the top level holds the cfg decode/ready mux only.

Verification
REQ-036 Reset release, no writes -> first tick_a at edge 5 and every 5 edges; clk_a period 10 cycles; first tick_b at edge 50; clk_b period 100 cycles.
REQ-037 Write A N=9, en=1, mid half-period -> busy[0]=1 until the next old terminal count; half-periods are 5 before and 10 after; clk_b is unaffected.
REQ-038 Write B en=0 while clk_b=0 -> one more rise and fall of clk_b, then clk_b=0, tick_b=0 permanently, and busy[1] returns to 0.
REQ-039 Second write to A while busy[0]=1 -> cfg_ready=0 and the write is held; it is accepted in the cycle after busy[0] falls and applied at the next terminal count.
REQ-040 Write A N=0 from OFF -> clk_a toggles every cycle, with tick_a continuously high starting 1 cycle after acceptance.
REQ-041 Assert reset while A is in PEND_UPD -> outputs 0 immediately; after release, clk_a has period 10 and the pending N is lost.
